// File: rtl/div_pkg.sv
// Shared types and constants for the shift/subtract divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // One extra bit keeps the carry when the shifted remainder exceeds 2^WIDTH-1.
  logic [WIDTH:0] shifted;

  assign shifted = {rem_i, bit_i};
  assign q_bit_o = (shifted >= {1'b0, divisor_i});
  assign rem_o   = WIDTH'(q_bit_o ? (shifted - {1'b0, divisor_i}) : shifted);

endmodule

// File: rtl/divider_8bit_shift_sub.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module divider_8bit_shift_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             done_q;
  logic             busy_q;
  logic             dbz_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] quo_res_d;
  logic [WIDTH-1:0] rem_res_d;
  logic [WIDTH-1:0] dvd_load_d;
  logic [WIDTH-1:0] dsr_load_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  // Quotient bits are shifted into the dividend register as its bits are consumed.
  assign quo_fin = {dvd_q[WIDTH-2:0], step_qbit};

`ifdef DIVIDER_SIGNED_EN
  logic neg_quo_q;
  logic neg_rem_q;

  assign dvd_load_d = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
  assign dsr_load_d = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
  assign quo_res_d  = neg_quo_q ? WIDTH'(-quo_fin)  : quo_fin;
  assign rem_res_d  = neg_rem_q ? WIDTH'(-step_rem) : step_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_q <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_load_d = dividend;
  assign dsr_load_d = divisor;
  assign quo_res_d  = quo_fin;
  assign rem_res_d  = step_rem;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= dvd_load_d;
            dsr_q   <= dsr_load_d;
            rem_q   <= '0;
            count_q <= '0;
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q   <= step_rem;
          dvd_q   <= quo_fin;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST_STEP) begin
            quotient_q  <= quo_res_d;
            remainder_q <= rem_res_d;
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_8bit_shift_sub.sv
// Self-checking bench for divider_8bit_shift_sub: directed cases plus random pairs
// against an arithmetic reference model (signed model when DIVIDER_SIGNED_EN is defined).
module tb_divider_8bit_shift_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       done;
  logic       busy;
  logic       div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  divider_8bit_shift_sub #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: plain integer division of the operands as the spec interprets them.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic z);
    int sa;
    int sb;
`ifdef DIVIDER_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // Samples on falling edges until done; cyc is the falling-edge index (1 = first after accept).
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 1;
    busy_cyc = 0;
    while (1) begin
      if (busy) busy_cyc++;
      if (done || cyc >= 40) break;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int cyc;
    int busy_cyc;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, busy_cyc);
    $display("op %s: 0x%02h / 0x%02h -> q=0x%02h r=0x%02h z=%0b lat=%0d",
             tag, a, b, quotient, remainder, div_by_zero, cyc);
    check({tag, "_lat"}, cyc, (b == 8'd0) ? 1 : 9);
    check({tag, "_busy_cycles"}, busy_cyc, (b == 8'd0) ? 0 : 8);
    check({tag, "_quo"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_width"}, done, 1'b0);
  endtask

  initial begin
    logic [7:0] a, b, eq, er;
    logic       ez;
    int         cyc;
    int         busy_cyc;

    rst      = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_quo", quotient, 8'd0);
    check("rst_rem", remainder, 8'd0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b1;

    run_op("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    run_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run_op("5/200", 8'd5, 8'd200, 8'd0, 8'd5, 1'b0);
    run_op("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    run_op("42/0", 8'd42, 8'd0, 8'hFF, 8'd42, 1'b1);
`ifdef DIVIDER_SIGNED_EN
    run_op("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
    run_op("100/-7", 8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0);
    run_op("-128/-1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0);
`else
    run_op("128/255", 8'd128, 8'd255, 8'd0, 8'd128, 1'b0);
    run_op("254/127", 8'd254, 8'd127, 8'd2, 8'd0, 1'b0);
`endif

    // start held high; operands changed mid-CALC must not affect the first result.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd13;
    start    = 1'b1;
    @(negedge clk);
    check("held_busy_after_accept", busy, 1'b1);
    repeat (2) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd3;
    @(negedge clk);
    wait_done(cyc, busy_cyc);
    $display("op held#1: 100/13 -> q=0x%02h r=0x%02h", quotient, remainder);
    check("held1_quo", quotient, 8'd7);
    check("held1_rem", remainder, 8'd9);
    @(negedge clk);
    check("held_idle_done", done, 1'b0);
    check("held_idle_busy", busy, 1'b0);
    @(negedge clk);
    check("held_reaccept_busy", busy, 1'b1);
    start = 1'b0;
    wait_done(cyc, busy_cyc);
    $display("op held#2: 50/3 -> q=0x%02h r=0x%02h lat=%0d", quotient, remainder, cyc);
    check("held2_lat", cyc, 9);
    check("held2_quo", quotient, 8'd16);
    check("held2_rem", remainder, 8'd2);
    @(negedge clk);
    check("held2_done_width", done, 1'b0);

    // Reset in the middle of CALC aborts with no done.
    @(negedge clk);
    dividend = 8'd120;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_quo", quotient, 8'd0);
    check("abort_rem", remainder, 8'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_dbz", div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_no_done", done, 1'b0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_late_done", done, 1'b0);
`ifdef DIVIDER_SIGNED_EN
    run_op("200/9", 8'd200, 8'd9, 8'hFA, 8'hFE, 1'b0);
`else
    run_op("200/9", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0);
`endif

    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      model(a, b, eq, er, ez);
      run_op($sformatf("rnd%0d", i), a, b, eq, er, ez);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
